// File: rtl/array_allocator_pkg.sv
// Shared bus types for the UM array allocator: memory command bus, mode
// encodings and the allocator FSM state.
package BusTypes;

    localparam logic [1:0] MEM_READ  = 2'b00;
    localparam logic [1:0] MEM_WRITE = 2'b01;

    typedef struct packed {
        logic [1:0]  mode;
        logic [31:0] address;
        logic [31:0] offset;
        logic [31:0] data;
    } mem_in_bus_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HEADER = 3'd1,
        ZERO   = 3'd2,
        DONE   = 3'd3,
        OOM    = 3'd4
    } allocator_state_t;

endpackage

// File: rtl/array_allocator_if.sv
// Request/response and memory-command signals of the array allocator.
// Handshake: req/size are sampled only while the allocator is IDLE; done or oom
// pulses for one cycle to close each request, and base is valid from done on.
interface array_allocator_if;
    import BusTypes::*;

    logic        req;
    logic [31:0] size;
    mem_in_bus_t mem_in;
    logic        busy;
    logic        done;
    logic        oom;
    logic [31:0] base;

    modport master (output req, size, input mem_in, busy, done, oom, base);
    modport slave  (input req, size, output mem_in, busy, done, oom, base);

endinterface

// File: rtl/array_allocator_accum.sv
// Word counter: synchronous clear, increment by one, hold otherwise.
module array_allocator_accum #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] value_o
);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (clr_i) begin
            value_d = '0;
        end else if (inc_i) begin
            value_d = value_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/array_allocator.sv
// Bump-pointer heap allocator: writes a length header, zero-fills the body,
// then returns the base of word 0. The heap is never freed.
module array_allocator
    import BusTypes::*;
#(
    parameter logic [31:0] HEAP_BASE  = 32'h0000_1000,
    parameter logic [31:0] HEAP_LIMIT = 32'h0010_0000
) (
    input  logic             clk,
    input  logic             rst,
    array_allocator_if.slave bus,
    output allocator_state_t dbg_state_o
);

    allocator_state_t state_q;
    logic [31:0]      top_q;
    logic [31:0]      base_q;
    logic [31:0]      size_q;
    logic [32:0]      end_q;
    logic             done_q;
    logic             oom_q;
    logic [31:0]      count;
    logic [32:0]      end_d;

    // 33-bit sum so an oversized request cannot wrap past the limit
    assign end_d = {1'b0, top_q} + {1'b0, bus.size} + 33'd1;

    array_allocator_accum #(.W(32)) u_count (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (state_q == IDLE),
        .inc_i   ((state_q == HEADER) || (state_q == ZERO)),
        .value_o (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            top_q   <= HEAP_BASE;
            base_q  <= '0;
            size_q  <= '0;
            end_q   <= '0;
            done_q  <= 1'b0;
            oom_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            oom_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req) begin
                        size_q <= bus.size;
                        end_q  <= end_d;
                        if (end_d > {1'b0, HEAP_LIMIT}) begin
                            state_q <= OOM;
                            oom_q   <= 1'b1;
                        end else begin
                            state_q <= HEADER;
                        end
                    end
                end
                HEADER: begin
                    if (size_q != '0) begin
                        state_q <= ZERO;
                    end else begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        base_q  <= top_q + 32'd1;
                    end
                end
                ZERO: begin
                    if (count == size_q) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        base_q  <= top_q + 32'd1;
                    end
                end
                DONE: begin
                    top_q   <= end_q[31:0];
                    state_q <= IDLE;
                end
                OOM: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        bus.mem_in         = '0;
        bus.mem_in.mode    = MEM_READ;
        bus.mem_in.address = top_q;
        case (state_q)
            HEADER: begin
                bus.mem_in.mode = MEM_WRITE;
                bus.mem_in.data = size_q;
            end
            ZERO: begin
                bus.mem_in.mode   = MEM_WRITE;
                bus.mem_in.offset = count;
            end
            default: begin
            end
        endcase
    end

    assign bus.busy    = (state_q == HEADER) || (state_q == ZERO);
    assign bus.done    = done_q;
    assign bus.oom     = oom_q;
    assign bus.base    = base_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_array_allocator.sv
// Directed bench for array_allocator on a small heap (limit 0x1010).
module tb_array_allocator;
    import BusTypes::*;

    logic             clk;
    logic             rst;
    allocator_state_t dbg_state;
    array_allocator_if aif();

    array_allocator #(
        .HEAP_BASE  (32'h0000_1000),
        .HEAP_LIMIT (32'h0000_1010)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (aif.slave),
        .dbg_state_o (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    int oom_cnt  = 0;
    logic [95:0] exp_q[$];

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Write scoreboard: every mode=01 cycle must match the next expected write
    always @(negedge clk) begin
        if (aif.mem_in.mode === MEM_WRITE) begin
            chk("write_pending", 96'(exp_q.size() != 0), 96'd1);
            if (exp_q.size() != 0) begin
                chk("write", {aif.mem_in.address, aif.mem_in.offset, aif.mem_in.data},
                    exp_q.pop_front());
            end
        end
        if (aif.done === 1'b1) done_cnt++;
        if (aif.oom === 1'b1) oom_cnt++;
    end

    task automatic push_alloc(input logic [31:0] top, input logic [31:0] sz);
        exp_q.push_back({top, 32'd0, sz});
        for (int i = 1; i <= int'(sz); i++) exp_q.push_back({top, 32'(i), 32'd0});
    endtask

    task automatic check_idle(input string tag, input logic [31:0] exp_top, input logic [31:0] exp_base);
        @(negedge clk);
        chk({tag, "_state"}, 96'(dbg_state), 96'(IDLE));
        chk({tag, "_busy"}, 96'(aif.busy), 96'd0);
        chk({tag, "_done"}, 96'(aif.done), 96'd0);
        chk({tag, "_oom"}, 96'(aif.oom), 96'd0);
        chk({tag, "_mode"}, 96'(aif.mem_in.mode), 96'(MEM_READ));
        chk({tag, "_top"}, 96'(aif.mem_in.address), 96'(exp_top));
        chk({tag, "_base"}, 96'(aif.base), 96'(exp_base));
        @(posedge clk); #1;
    endtask

    task automatic wait_event(output int lat);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (aif.done === 1'b1 || aif.oom === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic alloc(input string tag, input logic [31:0] sz, input logic [31:0] top,
                         input bit exp_oom, input logic [31:0] exp_base, input logic [31:0] exp_top);
        int lat;
        int exp_lat;
        if (!exp_oom) push_alloc(top, sz);
        exp_lat = exp_oom ? 1 : (sz == 0 ? 2 : int'(sz) + 2);
        aif.req  = 1'b1;
        aif.size = sz;
        @(posedge clk); #1;
        aif.req  = 1'b0;
        aif.size = $urandom_range(0, 255);
        wait_event(lat);
        chk({tag, "_lat"}, 96'(lat), 96'(exp_lat));
        chk({tag, "_oom_flag"}, 96'(aif.oom), 96'(exp_oom));
        chk({tag, "_base"}, 96'(aif.base), 96'(exp_base));
        check_idle(tag, exp_top, exp_base);
        chk({tag, "_drained"}, 96'(exp_q.size()), 96'd0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle(tag, 32'h1000, 32'h0);
    endtask

    initial begin
        int lat;
        int d0;
        rst      = 1'b1;
        aif.req  = 1'b0;
        aif.size = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_idle("reset", 32'h1000, 32'h0);

        alloc("a_size3", 32'd3, 32'h1000, 1'b0, 32'h1001, 32'h1004);
        alloc("a_size0", 32'd0, 32'h1004, 1'b0, 32'h1005, 32'h1005);
        alloc("a_oom20", 32'h20, 32'h1005, 1'b1, 32'h1005, 32'h1005);
        alloc("a_oom_max", 32'hFFFF_FFFF, 32'h1005, 1'b1, 32'h1005, 32'h1005);
        alloc("a_fit", 32'hA, 32'h1005, 1'b0, 32'h1006, 32'h1010);
        alloc("a_full", 32'd0, 32'h1010, 1'b1, 32'h1006, 32'h1010);

        do_reset("rst_b");
        alloc("b_fit", 32'hF, 32'h1000, 1'b0, 32'h1001, 32'h1010);

        // Reset during the third zero-fill cycle abandons the allocation
        do_reset("rst_c");
        push_alloc(32'h1000, 32'd3);
        exp_q[0] = {32'h1000, 32'd0, 32'd8};
        aif.req  = 1'b1;
        aif.size = 32'd8;
        @(posedge clk); #1;
        aif.req = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        d0  = done_cnt;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle("c_abort", 32'h1000, 32'h0);
        chk("c_no_done", 96'(done_cnt - d0), 96'd0);
        chk("c_drained", 96'(exp_q.size()), 96'd0);
        alloc("c_size1", 32'd1, 32'h1000, 1'b0, 32'h1001, 32'h1002);

        // Re-pulsed req and changed size mid-allocation are ignored
        push_alloc(32'h1002, 32'd4);
        d0       = done_cnt;
        aif.req  = 1'b1;
        aif.size = 32'd4;
        @(posedge clk); #1;
        aif.req  = 1'b0;
        aif.size = 32'd0;
        @(posedge clk); #1;
        aif.req  = 1'b1;
        aif.size = 32'd9;
        @(posedge clk); #1;
        aif.req = 1'b0;
        wait_event(lat);
        chk("d_lat", 96'(lat), 96'd4);
        chk("d_base", 96'(aif.base), 96'h1003);
        check_idle("d_after", 32'h1007, 32'h1003);
        chk("d_one_done", 96'(done_cnt - d0), 96'd1);
        chk("d_drained", 96'(exp_q.size()), 96'd0);

        // Held req: second allocation starts after one IDLE cycle
        push_alloc(32'h1007, 32'd1);
        push_alloc(32'h1009, 32'd1);
        aif.req  = 1'b1;
        aif.size = 32'd1;
        @(posedge clk); #1;
        wait_event(lat);
        chk("e1_lat", 96'(lat), 96'd3);
        chk("e1_base", 96'(aif.base), 96'h1008);
        @(negedge clk);
        chk("e_gap_busy", 96'(aif.busy), 96'd0);
        chk("e_gap_top", 96'(aif.mem_in.address), 96'h1009);
        @(posedge clk); #1;
        aif.req = 1'b0;
        @(negedge clk);
        chk("e2_busy", 96'(aif.busy), 96'd1);
        chk("e2_hdr_addr", 96'(aif.mem_in.address), 96'h1009);
        @(posedge clk); #1;
        wait_event(lat);
        chk("e2_lat", 96'(lat), 96'd2);
        chk("e2_base", 96'(aif.base), 96'h100A);
        check_idle("e_after", 32'h100B, 32'h100A);

        chk("final_drained", 96'(exp_q.size()), 96'd0);
        chk("final_done_cnt", 96'(done_cnt), 96'd8);
        chk("final_oom_cnt", 96'(oom_cnt), 96'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
